alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared external ALU: one operation in flight,
// round-robin on ties, registered ALU drive and registered response held until consumed.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [3:0]       req_ctrl_0,
    input  logic [3:0]       req_ctrl_1,

    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ltu,
    output logic             rsp_geu,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_ltu,
    input  logic             alu_geu
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ltu_q, rsp_ltu_d;
    logic             rsp_geu_q, rsp_geu_d;

    logic             grant_valid;
    logic             grant_sel;
    logic             resp_done;

    // Grant is only offered in idle; on a tie the requester that did not win last time goes.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state_q == StIdle && !reset) begin
            if (req_valid_0 && req_valid_1) begin
                grant_valid = 1'b1;
                grant_sel   = ~last_grant_q;
            end else if (req_valid_0) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (req_valid_1) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    // The non-owner's rsp_ready is deliberately not looked at.
    assign resp_done = (state_q == StResp) && (owner_q ? rsp_ready_1 : rsp_ready_0);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ltu_d    = rsp_ltu_q;
        rsp_geu_d    = rsp_geu_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d      = StExec;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    alu_a_d      = grant_sel ? req_a_1 : req_a_0;
                    alu_b_d      = grant_sel ? req_b_1 : req_b_0;
                    alu_ctrl_d   = grant_sel ? req_ctrl_1 : req_ctrl_0;
                end
            end
            StExec: begin
                state_d    = StResp;
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                rsp_ltu_d  = alu_ltu;
                rsp_geu_d  = alu_geu;
            end
            StResp: begin
                if (resp_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ltu_q    <= 1'b0;
            rsp_geu_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ltu_q    <= rsp_ltu_d;
            rsp_geu_q    <= rsp_geu_d;
        end
    end

    assign req_ready_0 = grant_valid & ~grant_sel;
    assign req_ready_1 = grant_valid & grant_sel;
    assign rsp_valid_0 = (state_q == StResp) & ~owner_q;
    assign rsp_valid_1 = (state_q == StResp) & owner_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_ltu     = rsp_ltu_q;
    assign rsp_geu     = rsp_geu_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the alu_* port group.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid_0, req_valid_1;
    logic         req_ready_0, req_ready_1;
    logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [3:0]   req_ctrl_0, req_ctrl_1;
    logic         rsp_valid_0, rsp_valid_1;
    logic         rsp_ready_0, rsp_ready_1;
    logic [W-1:0] rsp_data;
    logic         rsp_zero, rsp_ltu, rsp_geu;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_ctrl;
    logic         alu_zero, alu_ltu, alu_geu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ltu(rsp_ltu), .rsp_geu(rsp_geu),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ltu(alu_ltu), .alu_geu(alu_geu)
    );

    // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, others 0.
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            4'd0: alu_out = alu_a + alu_b;
            4'd1: alu_out = alu_a - alu_b;
            4'd2: alu_out = alu_a & alu_b;
            4'd3: alu_out = alu_a | alu_b;
            4'd4: alu_out = alu_a ^ alu_b;
            4'd5: alu_out = alu_a << alu_b[4:0];
            4'd6: alu_out = alu_a >> alu_b[4:0];
            4'd7: alu_out = $signed(alu_a) >>> alu_b[4:0];
            4'd8: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'd9: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = (alu_out == '0);
    assign alu_ltu  = (alu_a < alu_b);
    assign alu_geu  = (alu_a >= alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        req_a_0 = '0; req_b_0 = '0; req_a_1 = '0; req_b_1 = '0;
        req_ctrl_0 = '0; req_ctrl_1 = '0;
        tick();
        tick();
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got %b exp 00", {req_ready_0, req_ready_1});
        end
        checks++;
        if ({rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_rsp_bits got %b exp 00000",
                     {rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu});
        end
        checks++;
        if ({rsp_data, alu_a, alu_b, alu_ctrl} !== {W'(0), W'(0), W'(0), 4'd0}) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", rsp_data, alu_a, alu_b, alu_ctrl);
        end
        reset = 1'b0;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        tick();
        // last_grant resets to 1, so a tie goes to requester 0; withdraw before the edge.
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_tie_grant got %b exp 10", {req_ready_0, req_ready_1});
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        tick();
        req_valid_1 = 1'b1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1} !== 4'b0100) begin
            errors++;
            $display("FAIL withdraw_no_grant got %b exp 0100",
                     {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1});
        end
        req_valid_1 = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        req_valid_0 = 1'b1; req_a_0 = 32'd5; req_b_0 = 32'd3; req_ctrl_0 = 4'd1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready got %b exp 10", {req_ready_0, req_ready_1});
        end
        tick();
        req_valid_0 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, alu_a, alu_b, alu_ctrl} !==
            {2'b00, 32'd5, 32'd3, 4'd1}) begin
            errors++;
            $display("FAIL single_exec got %b%b %h %h %h exp 00 5 3 1",
                     rsp_valid_0, rsp_valid_1, alu_a, alu_b, alu_ctrl);
        end
        tick();
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, rsp_data} !==
            {5'b10001, 32'd2}) begin
            errors++;
            $display("FAIL single_resp got %b%b%b%b%b %h exp 10001 2",
                     rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, rsp_data);
        end
        rsp_ready_0 = 1'b1;
        tick();
        rsp_ready_0 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++;
            $display("FAIL single_done got %b exp 00", {rsp_valid_0, rsp_valid_1});
        end
    endtask

    task automatic test_tie();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid_0 = 1'b1; req_a_0 = 32'd1;    req_b_0 = 32'd1;    req_ctrl_0 = 4'd0;
        req_valid_1 = 1'b1; req_a_1 = 32'hF0;   req_b_1 = 32'h3C;   req_ctrl_1 = 4'd2;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first_grant got %b exp 10", {req_ready_0, req_ready_1});
        end
        tick();
        req_valid_0 = 1'b0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b00) begin
            errors++;
            $display("FAIL tie_exec_ready got %b exp 00", {req_ready_0, req_ready_1});
        end
        tick();
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, rsp_data} !== {2'b10, 32'd2}) begin
            errors++;
            $display("FAIL tie_resp0 got %b%b %h exp 10 2", rsp_valid_0, rsp_valid_1, rsp_data);
        end
        rsp_ready_0 = 1'b1;
        tick();
        rsp_ready_0 = 1'b0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++;
            $display("FAIL tie_second_grant got %b exp 01", {req_ready_0, req_ready_1});
        end
        tick();
        req_valid_1 = 1'b0;
        tick();
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, rsp_data} !== {2'b01, 32'h30}) begin
            errors++;
            $display("FAIL tie_resp1 got %b%b %h exp 01 30", rsp_valid_0, rsp_valid_1, rsp_data);
        end
        rsp_ready_1 = 1'b1;
        tick();
        rsp_ready_1 = 1'b0;
    endtask

    task automatic test_round_robin();
        bit         exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_vec;
        logic [W-1:0] exp_data;
        req_valid_0 = 1'b1; req_a_0 = 32'd10; req_b_0 = 32'd20; req_ctrl_0 = 4'd0;
        req_valid_1 = 1'b1; req_a_1 = 32'd9;  req_b_1 = 32'd4;  req_ctrl_1 = 4'd5;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_vec  = exp_order[i] ? 2'b01 : 2'b10;
            exp_data = exp_order[i] ? 32'd144 : 32'd30;
            #1;
            checks++;
            if ({req_ready_0, req_ready_1} !== exp_vec) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", i, {req_ready_0, req_ready_1}, exp_vec);
            end
            tick();
            tick();
            #1;
            checks++;
            if ({rsp_valid_0, rsp_valid_1, rsp_data} !== {exp_vec, exp_data}) begin
                errors++;
                $display("FAIL rr_resp%0d got %b%b %h exp %b %h",
                         i, rsp_valid_0, rsp_valid_1, rsp_data, exp_vec, exp_data);
            end
            tick();
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        req_valid_1 = 1'b1; req_a_1 = 32'd7; req_b_1 = 32'd7; req_ctrl_1 = 4'd1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++;
            $display("FAIL bp_grant got %b exp 01", {req_ready_0, req_ready_1});
        end
        tick();
        req_valid_1 = 1'b0;
        req_valid_0 = 1'b1; req_a_0 = 32'd100; req_b_0 = 32'd1; req_ctrl_0 = 4'd0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, req_ready_0, req_ready_1,
                 rsp_data, alu_a} !== {7'b0110100, 32'd0, 32'd7}) begin
                errors++;
                $display("FAIL bp_hold%0d got %b%b%b%b%b%b%b %h %h exp 0110100 0 7", i,
                         rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu,
                         req_ready_0, req_ready_1, rsp_data, alu_a);
            end
            tick();
        end
        req_valid_0 = 1'b0;
        rsp_ready_1 = 1'b1;
        tick();
        rsp_ready_1 = 1'b0;
        req_valid_0 = 1'b1;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, req_ready_0} !== 3'b001) begin
            errors++;
            $display("FAIL bp_idle got %b exp 001", {rsp_valid_0, rsp_valid_1, req_ready_0});
        end
        req_valid_0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_exec();
        req_valid_0 = 1'b1; req_a_0 = 32'd3; req_b_0 = 32'd4; req_ctrl_0 = 4'd3;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++;
            $display("FAIL rex_grant got %b exp 10", {req_ready_0, req_ready_1});
        end
        tick();
        req_valid_0 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rsp_valid_0, rsp_valid_1, rsp_data, alu_a, alu_ctrl} !==
                {2'b00, W'(0), W'(0), 4'd0}) begin
                errors++;
                $display("FAIL rex_flushed%0d got %b%b %h %h %h exp 00 0 0 0", i,
                         rsp_valid_0, rsp_valid_1, rsp_data, alu_a, alu_ctrl);
            end
            tick();
        end
        req_valid_1 = 1'b1; req_a_1 = 32'd2; req_b_1 = 32'd3; req_ctrl_1 = 4'd9;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++;
            $display("FAIL rex_next_grant got %b exp 01", {req_ready_0, req_ready_1});
        end
        tick();
        req_valid_1 = 1'b0;
        tick();
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, rsp_data} !==
            {5'b01010, 32'd1}) begin
            errors++;
            $display("FAIL rex_next_resp got %b%b%b%b%b %h exp 01010 1",
                     rsp_valid_0, rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, rsp_data);
        end
        rsp_ready_1 = 1'b1;
        tick();
        rsp_ready_1 = 1'b0;
    endtask

    task automatic test_non_owner_ready();
        req_valid_0 = 1'b1; req_a_0 = 32'hFF; req_b_0 = 32'h0F; req_ctrl_0 = 4'd4;
        tick();
        req_valid_0 = 1'b0;
        tick();
        rsp_ready_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rsp_valid_0, rsp_valid_1, rsp_data} !== {2'b10, 32'hF0}) begin
                errors++;
                $display("FAIL nonowner_hold%0d got %b%b %h exp 10 f0",
                         i, rsp_valid_0, rsp_valid_1, rsp_data);
            end
            tick();
        end
        rsp_ready_1 = 1'b0;
        rsp_ready_0 = 1'b1;
        tick();
        rsp_ready_0 = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
            errors++;
            $display("FAIL nonowner_done got %b exp 00", {rsp_valid_0, rsp_valid_1});
        end
    endtask

    task automatic test_ctrl_passthrough();
        req_valid_1 = 1'b1; req_a_1 = 32'h1234; req_b_1 = 32'h5678; req_ctrl_1 = 4'hC;
        tick();
        req_valid_1 = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== {32'h1234, 32'h5678, 4'hC}) begin
            errors++;
            $display("FAIL ctrl_forward got %h %h %h exp 1234 5678 c", alu_a, alu_b, alu_ctrl);
        end
        tick();
        #1;
        checks++;
        if ({rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, rsp_data} !== {4'b1110, 32'd0}) begin
            errors++;
            $display("FAIL ctrl_result got %b%b%b%b %h exp 1110 0",
                     rsp_valid_1, rsp_zero, rsp_ltu, rsp_geu, rsp_data);
        end
        rsp_ready_1 = 1'b1;
        tick();
        rsp_ready_1 = 1'b0;
        req_a_1 = 32'hDEAD; req_b_1 = 32'hBEEF; req_ctrl_1 = 4'd0;
        tick();
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== {32'h1234, 32'h5678, 4'hC}) begin
            errors++;
            $display("FAIL alu_hold got %h %h %h exp 1234 5678 c", alu_a, alu_b, alu_ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_tie();
        test_round_robin();
        test_backpressure();
        test_reset_in_exec();
        test_non_owner_ready();
        test_ctrl_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
